// File: rtl/button_pkg.sv
// Shared types and constants for the bouncing-button generator.
package button_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      GLITCH_AWAY = 3'd1,
      GLITCH_BACK = 3'd2,
      SETTLE      = 3'd3,
      DONE        = 3'd4
   } state_e;

   // Fibonacci taps 16,14,13,11 as a bit mask over q[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Debouncer window the settle time has to outlast
   localparam int unsigned DEB_WINDOW = 999999;

endpackage

// File: rtl/button_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step is high.
module lfsr16
   import button_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (step) begin
         q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q <= seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/button_bounce_gen.sv
// Bouncing-button generator: turns press/release commands into an active-low
// contact waveform with glitches. Define BOUNCE_LFSR_EN for random glitch widths.
module button_bounce_gen
   import button_pkg::*;
#(
   parameter int unsigned BOUNCE_MAX = 8,
   parameter int unsigned SEG_BITS   = 12,
   parameter int unsigned SEG_FIX    = 1000,
   parameter int unsigned SETTLE_CYC = 1000000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter bit          SETTLE_CHK = 1'b1
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       press_req,
   input  logic       release_req,
   input  logic [3:0] n_bounce,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       but_o,
   output logic       level_o
);

   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);

   // Elaboration-time parameter sanity
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end
   if (SEG_BITS < 1 || SEG_BITS > 16) begin : g_bad_seg_bits
      $error("SEG_BITS must be within 1..16");
   end
   if (SEG_FIX < 1) begin : g_bad_seg_fix
      $error("SEG_FIX must be at least 1");
   end
   if (SETTLE_CYC < 1) begin : g_bad_settle_zero
      $error("SETTLE_CYC must be at least 1");
   end
   if (SETTLE_CHK && SETTLE_CYC <= DEB_WINDOW) begin : g_bad_settle
      $error("SETTLE_CYC must exceed the debounce window");
   end

   state_e      state_d, state_q;
   logic        target_d, target_q;
   logic [3:0]  gcnt_d, gcnt_q;
   logic [31:0] cnt_d, cnt_q;
   logic [31:0] seg_last_d, seg_last_q;
   logic        but_d, but_q;
   logic        level_d, level_q;
   logic        busy_d, busy_q;
   logic        done_d, done_q;
   logic        err_d, err_q;

   logic        seg_load_c;
   logic [31:0] seg_next_c;
   logic [3:0]  nb_clamp_c;
   logic        req_bad_c;

`ifdef BOUNCE_LFSR_EN
   logic [15:0] lfsr_q;
   logic        unused_lfsr;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rstn (rstn),
      .step (seg_load_c),
      .seed (LFSR_SEED),
      .q    (lfsr_q)
   );

   // Segment length minus one, taken before the LFSR advances
   assign seg_next_c  = 32'(lfsr_q[SEG_BITS-1:0]);
   assign unused_lfsr = ^lfsr_q;
`else
   logic unused_load;

   assign seg_next_c  = 32'(SEG_FIX - 1);
   assign unused_load = seg_load_c;
`endif

   assign nb_clamp_c = (32'(n_bounce) > BOUNCE_MAX) ? 4'(BOUNCE_MAX) : n_bounce;
   assign req_bad_c  = (press_req && release_req) ||
                       (press_req && level_q) ||
                       (release_req && !level_q);

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      gcnt_d     = gcnt_q;
      cnt_d      = cnt_q;
      seg_last_d = seg_last_q;
      but_d      = but_q;
      level_d    = level_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      seg_load_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (press_req || release_req) begin
               if (req_bad_c) begin
                  err_d = 1'b1;
               end else begin
                  // A release drives the contact high, a press drives it low
                  target_d = release_req;
                  but_d    = release_req;
                  busy_d   = 1'b1;
                  gcnt_d   = nb_clamp_c;
                  cnt_d    = 32'd0;
                  if (nb_clamp_c != 4'd0) begin
                     state_d    = GLITCH_AWAY;
                     seg_last_d = seg_next_c;
                     seg_load_c = 1'b1;
                  end else begin
                     state_d = SETTLE;
                  end
               end
            end
         end

         GLITCH_AWAY: begin
            if (cnt_q == seg_last_q) begin
               state_d    = GLITCH_BACK;
               but_d      = ~target_q;
               cnt_d      = 32'd0;
               seg_last_d = seg_next_c;
               seg_load_c = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         GLITCH_BACK: begin
            if (cnt_q == seg_last_q) begin
               but_d  = target_q;
               cnt_d  = 32'd0;
               gcnt_d = gcnt_q - 4'd1;
               if (gcnt_q != 4'd1) begin
                  state_d    = GLITCH_AWAY;
                  seg_last_d = seg_next_c;
                  seg_load_c = 1'b1;
               end else begin
                  state_d = SETTLE;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = DONE;
               cnt_d   = 32'd0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               level_d = ~target_q;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         target_q   <= 1'b1;
         gcnt_q     <= 4'd0;
         cnt_q      <= 32'd0;
         seg_last_q <= 32'd0;
         but_q      <= 1'b1;
         level_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         gcnt_q     <= gcnt_d;
         cnt_q      <= cnt_d;
         seg_last_q <= seg_last_d;
         but_q      <= but_d;
         level_q    <= level_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign but_o   = but_q;
   assign level_o = level_q;

endmodule
